// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants.
// Holds the default register-file geometry used by decode, writeback and the
// register file, plus the two-state encoding of the register-file clear
// sequencer.
package cpu_pkg;

  // Default register-file geometry shared across the datapath.
  localparam int unsigned RF_DATA_W = 16;
  localparam int unsigned RF_ADDR_W = 2;

  // Register-file clear sequencer states.
  localparam logic RF_ST_IDLE  = 1'b0;
  localparam logic RF_ST_CLEAR = 1'b1;

  // Number of entries for a given address width.
  function automatic int unsigned rf_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Register-file clear sequencer.
// After reset, or on a soft-clear request while idle, sweeps every entry
// once, issuing one zero-write per cycle, then returns to idle.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset; restarts the sweep at entry 0
//   clr_req  - one-cycle pulse; starts a sweep when idle, ignored otherwise
//   ready    - 1 when idle (no sweep in progress)
//   clr_we   - zero-write strobe for the storage array
//   clr_addr - entry being zeroed this cycle
module regfile_clear_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] CntLast = '1;

  logic              state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_ST_IDLE: begin
        if (clr_req) begin
          state_d = RF_ST_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_ST_CLEAR: begin
        // The last entry is zeroed in the same cycle the state flips back.
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == CntLast) begin
          state_d = RF_ST_IDLE;
        end
      end
      default: begin
        state_d = RF_ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready    = (state_q == RF_ST_IDLE);
  assign clr_we   = (state_q == RF_ST_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised CPU register file: 2**ADDR_W entries of DATA_W bits, one write
// port, two registered (1-cycle) read ports, hardware clear after reset or on
// request, and optional hardwired-zero entry 0.
// Build option: define REGFILE_BYPASS_EN for write-first behaviour on a
// same-cycle read/write of one address; otherwise reads return the old value.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   clr_req  - one-cycle pulse requesting a clear of every entry
//   ready    - 1 when idle: writes accepted, reads valid
//   we       - write enable (dropped while not ready)
//   w_addr   - write address
//   w_data   - write data
//   r_addr1  - read address, port 1
//   r_addr2  - read address, port 2
//   r_data1  - registered read data, port 1
//   r_data2  - registered read data, port 2
module regfile_param
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned ADDR_W  = RF_ADDR_W,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr1,
  input  logic [ADDR_W-1:0] r_addr2,
  output logic [DATA_W-1:0] r_data1,
  output logic [DATA_W-1:0] r_data2
);

  localparam int unsigned Depth  = rf_depth(ADDR_W);
  localparam bit          ZeroR0 = (ZERO_R0 != 0);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  regfile_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Storage. No reset: the clear sweep zeroes it, and reads are forced to
  // zero until the sweep completes.
  logic [DATA_W-1:0] mem_q [Depth];

  logic              ext_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // An external write is only accepted while idle and not in reset.
  assign ext_we = we & ready & ~rst;

  // Clear sweep and external writes never overlap (ready is low while
  // sweeping), so the priority order only matters for readability.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = w_addr;
    mem_wdata = w_data;
    if (!rst) begin
      if (clr_we) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = '0;
      end else if (ext_we && !(ZeroR0 && (w_addr == '0))) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read ports, handled as a two-element array to keep both paths identical.
  logic [ADDR_W-1:0] r_addr [2];
  logic [DATA_W-1:0] rd_d   [2];
  logic [DATA_W-1:0] rd_q   [2];

  assign r_addr[0] = r_addr1;
  assign r_addr[1] = r_addr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_d[p] = '0;
      if (ready && !(ZeroR0 && (r_addr[p] == '0))) begin
        rd_d[p] = mem_q[r_addr[p]];
`ifdef REGFILE_BYPASS_EN
        // Write-first: forward the accepted write data to a matching read.
        if (ext_we && (w_addr == r_addr[p])) begin
          rd_d[p] = w_data;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q[0] <= '0;
      rd_q[1] <= '0;
    end else begin
      rd_q[0] <= rd_d[0];
      rd_q[1] <= rd_d[1];
    end
  end

  assign r_data1 = rd_q[0];
  assign r_data2 = rd_q[1];

endmodule
